// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single program/data memory of the 16-bit processor between two
// requesters: port 0 is the core (instruction fetch and LOAD/STORE), port 1
// is the program loader / debug port. Arbitration is round-robin, with an
// optional per-port lock that lets the most recent winner keep the memory for
// an atomic read-modify-write sequence. Only one transaction is in flight at
// a time; reads hold the arbiter in WAIT until the memory macro returns data.
//
// Parameters
//   ADDR_W   memory address width
//   DATA_W   memory word width (16-bit data is zero-extended by requesters)
//   RD_LAT   memory read latency in cycles, 1..4
//
// Ports
//   clk, rst                 system clock, synchronous active-high reset
//   pN_req/we/addr/wdata     port N request and its fields (N = 0, 1); the
//                            fields are sampled only in the grant cycle
//   pN_lock                  port N keeps ownership while high and requesting
//   pN_gnt                   port N accepted this cycle (combinational)
//   pN_rvalid                port N read data valid, one-cycle pulse
//   pN_rdata                 port N read data, holds last returned value
//   p0_stall                 core pipeline hold: p0_req and no p0_gnt
//   mem_en/we/addr/wdata     memory access strobe and fields, all zero when
//                            no grant is issued
//   mem_rdata                memory read data, valid RD_LAT cycles after issue
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 26,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p0_lock,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_stall,

  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic              p1_lock,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t     state;
  // Port that won the most recent grant; 1 out of reset so port 0 goes first.
  logic       last;
  // Port whose read is currently in flight.
  logic       owner;
  logic [2:0] wait_cnt;
  logic       any_gnt;

  // Winner selection. Grants are only possible in IDLE. With both ports
  // requesting, the previous winner keeps the memory if it holds its lock;
  // otherwise the port that did not win last time is served. A lock raised by
  // the other port is ignored because that port is not `last`.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (state == IDLE) begin
      if (p0_req && p1_req) begin
        if (!last && p0_lock) begin
          p0_gnt = 1'b1;
        end else if (last && p1_lock) begin
          p1_gnt = 1'b1;
        end else if (last) begin
          p0_gnt = 1'b1;
        end else begin
          p1_gnt = 1'b1;
        end
      end else if (p0_req) begin
        p0_gnt = 1'b1;
      end else if (p1_req) begin
        p1_gnt = 1'b1;
      end
    end
  end

  assign any_gnt  = p0_gnt | p1_gnt;
  assign p0_stall = p0_req & ~p0_gnt;

  // Memory command is driven straight from the winning port in the grant
  // cycle and forced to zero otherwise, so the macro sees a clean idle bus.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (p0_gnt) begin
      mem_en    = 1'b1;
      mem_we    = p0_we;
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
    end else if (p1_gnt) begin
      mem_en    = 1'b1;
      mem_we    = p1_we;
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
    end
  end

  // Sequencing FSM. A write completes in its grant cycle, so IDLE can grant
  // again next cycle. A read loads the latency counter and waits; the word is
  // captured on the edge where the counter reads 1 (end of cycle issue+RD_LAT)
  // and the rvalid pulse lands on the following cycle, which is already IDLE.
  // Reset drops any read in flight without producing rvalid for it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      owner     <= 1'b0;
      wait_cnt  <= '0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (any_gnt) begin
            last <= p1_gnt;
            if (!mem_we) begin
              state    <= WAIT;
              wait_cnt <= 3'(RD_LAT);
              owner    <= p1_gnt;
            end
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
          if (wait_cnt == 3'd1) begin
            state <= IDLE;
            if (owner) begin
              p1_rvalid <= 1'b1;
              p1_rdata  <= mem_rdata;
            end else begin
              p0_rvalid <= 1'b1;
              p0_rdata  <= mem_rdata;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. Instance `dut` uses RD_LAT=1 with a small
// behavioural memory; instance `dut_b` uses RD_LAT=3 with a constant read
// word and is used for the reset-during-read scenario. Inputs change 1 time
// unit after each rising edge and outputs are sampled 1 unit later.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk;
  logic        rst;

  logic        p0_req, p0_we, p0_lock;
  logic [15:0] p0_addr;
  logic [25:0] p0_wdata;
  logic        p1_req, p1_we, p1_lock;
  logic [15:0] p1_addr;
  logic [25:0] p1_wdata;

  logic        p0_gnt, p0_rvalid, p0_stall;
  logic [25:0] p0_rdata;
  logic        p1_gnt, p1_rvalid;
  logic [25:0] p1_rdata;

  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [25:0] mem_wdata;
  logic [25:0] mem_rdata;

  logic        b_rst;
  logic        b_p0_req;
  logic [15:0] b_p0_addr;
  logic        b_p0_gnt, b_p0_rvalid, b_p0_stall;
  logic [25:0] b_p0_rdata;
  logic        b_p1_gnt, b_p1_rvalid;
  logic [25:0] b_p1_rdata;
  logic        b_mem_en, b_mem_we;
  logic [15:0] b_mem_addr;
  logic [25:0] b_mem_wdata;

  int checks;
  int errors;

  logic [25:0] mem_model [logic [15:0]];

  mem_arbiter #(.ADDR_W(16), .DATA_W(26), .RD_LAT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .p0_req    (p0_req),
    .p0_we     (p0_we),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p0_lock   (p0_lock),
    .p0_gnt    (p0_gnt),
    .p0_rvalid (p0_rvalid),
    .p0_rdata  (p0_rdata),
    .p0_stall  (p0_stall),
    .p1_req    (p1_req),
    .p1_we     (p1_we),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p1_lock   (p1_lock),
    .p1_gnt    (p1_gnt),
    .p1_rvalid (p1_rvalid),
    .p1_rdata  (p1_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(26), .RD_LAT(3)) dut_b (
    .clk       (clk),
    .rst       (b_rst),
    .p0_req    (b_p0_req),
    .p0_we     (1'b0),
    .p0_addr   (b_p0_addr),
    .p0_wdata  (26'h0),
    .p0_lock   (1'b0),
    .p0_gnt    (b_p0_gnt),
    .p0_rvalid (b_p0_rvalid),
    .p0_rdata  (b_p0_rdata),
    .p0_stall  (b_p0_stall),
    .p1_req    (1'b0),
    .p1_we     (1'b0),
    .p1_addr   (16'h0),
    .p1_wdata  (26'h0),
    .p1_lock   (1'b0),
    .p1_gnt    (b_p1_gnt),
    .p1_rvalid (b_p1_rvalid),
    .p1_rdata  (b_p1_rdata),
    .mem_en    (b_mem_en),
    .mem_we    (b_mem_we),
    .mem_addr  (b_mem_addr),
    .mem_wdata (b_mem_wdata),
    .mem_rdata (26'h2AAAAAA)
  );

  // Free-running clock shared by both instances.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Contents of never-written locations: address 0 holds a known pattern,
  // everything else holds its own address.
  function automatic logic [25:0] initWord(input logic [15:0] a);
    return (a == 16'h0000) ? 26'h1234567 : {10'h0, a};
  endfunction

  // Behavioural memory with a one-cycle registered read for `dut`.
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem_model[mem_addr] = mem_wdata;
    end
    if (mem_en && !mem_we) begin
      mem_rdata <= mem_model.exists(mem_addr) ? mem_model[mem_addr] : initWord(mem_addr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int port, input logic req, input logic we,
                               input logic [15:0] addr, input logic [25:0] wdata,
                               input logic lock);
    if (port == 0) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_lock = lock;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_lock = lock;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Holds `dut` in reset for two edges with all ports quiet; returns in a
  // cycle where rst is still high so the caller can release it next cycle.
  task automatic resetA();
    rst = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 16'h0, 26'h0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, 16'h0, 26'h0, 1'b0);
    tick();
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    b_rst = 1'b1;
    b_p0_req = 1'b0;
    b_p0_addr = 16'h0;

    // ---- Reset state and single p0 read --------------------------------
    resetA();
    #1;
    checkOutput("rst_p0_rvalid", p0_rvalid, 0);
    checkOutput("rst_p1_rvalid", p1_rvalid, 0);
    checkOutput("rst_p0_rdata", p0_rdata, 0);
    checkOutput("rst_p1_rdata", p1_rdata, 0);
    checkOutput("rst_mem_en", mem_en, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);

    tick();
    rst = 1'b0;
    applyStimulus(0, 1'b1, 1'b0, 16'h0000, 26'h0, 1'b0);
    #1;
    checkOutput("rd0_c0_p0_gnt", p0_gnt, 1);
    checkOutput("rd0_c0_p1_gnt", p1_gnt, 0);
    checkOutput("rd0_c0_stall", p0_stall, 0);
    checkOutput("rd0_c0_mem_en", mem_en, 1);
    checkOutput("rd0_c0_mem_we", mem_we, 0);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 16'h0, 26'h0, 1'b0);
    #1;
    checkOutput("rd0_c1_p0_gnt", p0_gnt, 0);
    checkOutput("rd0_c1_mem_en", mem_en, 0);
    checkOutput("rd0_c1_rvalid", p0_rvalid, 0);
    tick();
    checkOutput("rd0_c2_rvalid", p0_rvalid, 1);
    checkOutput("rd0_c2_rdata", p0_rdata, 32'h1234567);
    tick();
    checkOutput("rd0_c3_rvalid", p0_rvalid, 0);
    checkOutput("rd0_c3_rdata_hold", p0_rdata, 32'h1234567);

    // ---- Both ports reading continuously: round-robin -------------------
    resetA();
    tick();
    rst = 1'b0;
    applyStimulus(0, 1'b1, 1'b0, 16'h0000, 26'h0, 1'b0);
    applyStimulus(1, 1'b1, 1'b0, 16'h0001, 26'h0, 1'b0);
    #1;
    for (int c = 0; c <= 6; c++) begin
      if (c != 0) tick();
      checkOutput($sformatf("rr_c%0d_p0_gnt", c), p0_gnt, (c == 0 || c == 4) ? 1 : 0);
      checkOutput($sformatf("rr_c%0d_p1_gnt", c), p1_gnt, (c == 2 || c == 6) ? 1 : 0);
      checkOutput($sformatf("rr_c%0d_both_gnt", c), p0_gnt & p1_gnt, 0);
      checkOutput($sformatf("rr_c%0d_stall", c), p0_stall, (c == 0 || c == 4) ? 0 : 1);
      checkOutput($sformatf("rr_c%0d_p0_rvalid", c), p0_rvalid, (c == 2 || c == 6) ? 1 : 0);
      checkOutput($sformatf("rr_c%0d_p1_rvalid", c), p1_rvalid, (c == 4) ? 1 : 0);
    end
    checkOutput("rr_p0_rdata", p0_rdata, 32'h1234567);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 16'h0, 26'h0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, 16'h0, 26'h0, 1'b0);
    tick();
    checkOutput("rr_c8_p1_rvalid", p1_rvalid, 1);
    checkOutput("rr_c8_p1_rdata", p1_rdata, 32'h1);

    // ---- p1 write then read at the top address --------------------------
    resetA();
    tick();
    rst = 1'b0;
    applyStimulus(1, 1'b1, 1'b1, 16'hFFFF, 26'h3FFFFFF, 1'b0);
    #1;
    checkOutput("wr_c0_p1_gnt", p1_gnt, 1);
    checkOutput("wr_c0_mem_we", mem_we, 1);
    checkOutput("wr_c0_mem_addr", mem_addr, 32'hFFFF);
    checkOutput("wr_c0_mem_wdata", mem_wdata, 32'h3FFFFFF);
    tick();
    applyStimulus(1, 1'b1, 1'b0, 16'hFFFF, 26'h0, 1'b0);
    #1;
    checkOutput("wr_c1_p1_rvalid", p1_rvalid, 0);
    checkOutput("wr_c1_p1_gnt", p1_gnt, 1);
    checkOutput("wr_c1_mem_we", mem_we, 0);
    tick();
    applyStimulus(1, 1'b0, 1'b0, 16'h0, 26'h0, 1'b0);
    #1;
    checkOutput("wr_c2_mem_en", mem_en, 0);
    tick();
    checkOutput("wr_c3_p1_rvalid", p1_rvalid, 1);
    checkOutput("wr_c3_p1_rdata", p1_rdata, 32'h3FFFFFF);
    checkOutput("wr_c3_p0_rvalid", p0_rvalid, 0);
    checkOutput("wr_c3_p0_rdata", p0_rdata, 0);

    // ---- p0 lock across read + write while p1 keeps requesting ----------
    resetA();
    tick();
    rst = 1'b0;
    applyStimulus(0, 1'b1, 1'b0, 16'h0010, 26'h0, 1'b1);
    applyStimulus(1, 1'b1, 1'b0, 16'h0020, 26'h0, 1'b0);
    #1;
    checkOutput("lk_c0_p0_gnt", p0_gnt, 1);
    checkOutput("lk_c0_p1_gnt", p1_gnt, 0);
    tick();
    applyStimulus(0, 1'b1, 1'b1, 16'h0010, 26'h0ABCDEF, 1'b1);
    #1;
    checkOutput("lk_c1_gnt", {p0_gnt, p1_gnt}, 0);
    checkOutput("lk_c1_stall", p0_stall, 1);
    tick();
    checkOutput("lk_c2_p0_rvalid", p0_rvalid, 1);
    checkOutput("lk_c2_p0_rdata", p0_rdata, 32'h10);
    checkOutput("lk_c2_p0_gnt", p0_gnt, 1);
    checkOutput("lk_c2_p1_gnt", p1_gnt, 0);
    checkOutput("lk_c2_mem_we", mem_we, 1);
    checkOutput("lk_c2_mem_addr", mem_addr, 32'h10);
    tick();
    applyStimulus(0, 1'b1, 1'b0, 16'h0010, 26'h0, 1'b0);
    #1;
    checkOutput("lk_c3_p1_gnt", p1_gnt, 1);
    checkOutput("lk_c3_p0_gnt", p0_gnt, 0);
    checkOutput("lk_c3_stall", p0_stall, 1);
    checkOutput("lk_c3_mem_addr", mem_addr, 32'h20);
    tick();
    checkOutput("lk_c4_stall", p0_stall, 1);
    checkOutput("lk_c4_gnt", {p0_gnt, p1_gnt}, 0);
    tick();
    checkOutput("lk_c5_p1_rvalid", p1_rvalid, 1);
    checkOutput("lk_c5_p1_rdata", p1_rdata, 32'h20);
    checkOutput("lk_c5_p0_gnt", p0_gnt, 1);
    checkOutput("lk_c5_p1_gnt", p1_gnt, 0);
    checkOutput("lk_c5_stall", p0_stall, 0);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 16'h0, 26'h0, 1'b0);
    #1;
    checkOutput("lk_c6_gnt", {p0_gnt, p1_gnt}, 0);
    tick();
    checkOutput("lk_c7_p0_rvalid", p0_rvalid, 1);
    checkOutput("lk_c7_p0_rdata", p0_rdata, 32'h0ABCDEF);
    checkOutput("lk_c7_p1_gnt", p1_gnt, 1);
    tick();
    applyStimulus(1, 1'b0, 1'b0, 16'h0, 26'h0, 1'b0);
    tick();
    tick();

    // ---- Back-to-back p0 writes -----------------------------------------
    resetA();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) tick();
      applyStimulus(0, 1'b1, 1'b1, 16'(i), 26'(32'h100 + i), 1'b0);
      #1;
      checkOutput($sformatf("bw_%0d_p0_gnt", i), p0_gnt, 1);
      checkOutput($sformatf("bw_%0d_mem_we", i), mem_we, 1);
      checkOutput($sformatf("bw_%0d_mem_addr", i), mem_addr, 32'(i));
      checkOutput($sformatf("bw_%0d_stall", i), p0_stall, 0);
    end
    tick();
    applyStimulus(0, 1'b0, 1'b0, 16'h0, 26'h0, 1'b0);
    #1;
    checkOutput("bw_idle_mem_en", mem_en, 0);
    checkOutput("bw_idle_mem_addr", mem_addr, 0);
    checkOutput("bw_idle_p0_rvalid", p0_rvalid, 0);

    // ---- RD_LAT=3: reset in the second WAIT cycle -----------------------
    rst = 1'b1;
    tick();
    tick();
    b_rst = 1'b0;
    b_p0_req = 1'b1;
    b_p0_addr = 16'h0005;
    #1;
    checkOutput("rl_c0_gnt", b_p0_gnt, 1);
    tick();
    b_p0_req = 1'b0;
    #1;
    checkOutput("rl_c1_gnt", b_p0_gnt, 0);
    tick();
    b_rst = 1'b1;
    #1;
    checkOutput("rl_c2_rvalid", b_p0_rvalid, 0);
    tick();
    b_rst = 1'b0;
    b_p0_req = 1'b1;
    b_p0_addr = 16'h0006;
    #1;
    checkOutput("rl_c3_gnt", b_p0_gnt, 1);
    checkOutput("rl_c3_mem_addr", b_mem_addr, 32'h6);
    checkOutput("rl_c3_rvalid", b_p0_rvalid, 0);
    for (int c = 4; c <= 6; c++) begin
      tick();
      b_p0_req = 1'b0;
      #1;
      checkOutput($sformatf("rl_c%0d_rvalid", c), b_p0_rvalid, 0);
      checkOutput($sformatf("rl_c%0d_gnt", c), b_p0_gnt, 0);
    end
    tick();
    checkOutput("rl_c7_rvalid", b_p0_rvalid, 1);
    checkOutput("rl_c7_rdata", b_p0_rdata, 32'h2AAAAAA);
    tick();
    checkOutput("rl_c8_rvalid", b_p0_rvalid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter that shares the single 65536 x 26-bit program/data memory of the 16-bit processor.
- Port 0 is the core (fetch and LOAD/STORE). Port 1 is the program loader/debug port, which replaces file preload and allows inspection while the core runs.
- Arbitration is round-robin with an optional per-port lock for atomic read-modify-write sequences.
- Handles read-latency sequencing of the memory macro: one transaction in flight at a time.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 26, memory word width (instruction width; 16-bit data zero-extended by requester).
- RD_LAT, 1, memory read latency in cycles, legal range 1..4.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- pN_req  input  1  port N request, N=0,1; held with fields stable until pN_gnt
- pN_we  input  1  port N write enable (1=write, 0=read)
- pN_addr  input  ADDR_W  port N address
- pN_wdata  input  DATA_W  port N write data
- pN_lock  input  1  port N keeps ownership while high and requesting
- pN_gnt  output  1  port N request accepted this cycle (combinational)
- pN_rvalid  output  1  port N read data valid, one-cycle pulse (registered)
- pN_rdata  output  DATA_W  port N read data, holds last value (registered)
- p0_stall  output  1  p0_req & ~p0_gnt, drives core pipeline hold
- mem_en  output  1  memory access strobe
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data, valid RD_LAT cycles after the issue cycle

Behaviour:
- Reset (clk edge with rst=1):
  - state=IDLE, last=1 (port 0 favoured first), wait counter=0.
  - pN_rvalid=0, pN_rdata=0.
  - mem_en, mem_we, mem_addr and mem_wdata are 0 whenever no grant is issued.
- Reset mid-read: the pending read is dropped and no rvalid is produced for it.
- States: IDLE, WAIT.
- IDLE:
  - If any pN_req is high, select a winner. Assert its pN_gnt and drive mem_en=1, mem_we=pN_we, mem_addr=pN_addr, mem_wdata=pN_wdata in the same cycle (issue cycle).
  - Write grant: state stays IDLE. Next cycle can grant again, giving 1 write/cycle throughput.
  - Read grant: go to WAIT, load counter=RD_LAT, record owner.
  - Only one gnt is ever high per cycle. No grant when no request.
- WAIT:
  - No grants, mem_en=0; counter decrements each cycle.
  - At the edge ending cycle issue+RD_LAT, register mem_rdata into the owner's pN_rdata, pulse owner's pN_rvalid for one cycle, and return to IDLE.
  - The rvalid cycle is an IDLE cycle, so a new grant may coincide with it.
  - Read occupancy is RD_LAT+1 cycles from issue to next possible issue.
- Arbitration:
  - Both requesting, no lock: grant the port not equal to last. last updates to the winner on every grant.
  - Single requester: granted regardless of last.
  - Lock: if last==N, pN_lock=1 and pN_req=1 in IDLE, port N wins even if the other port requests.
  - Lock is released when pN_lock=0 or pN_req=0 on an IDLE cycle.
  - Lock from the non-last port has no effect until that port wins normally.
- pN_rdata of the non-owner port is unchanged by a read. Writes never assert rvalid.
- Address is passed through unmodified, with no wrap or offset arithmetic (addr 16'hFFFF is legal).
- Requests changing fields before gnt are a protocol violation. The arbiter samples fields only in the grant cycle.

Test Plan:
- Reset then p0 read addr 16'h0000, memory model holds 26'h1234567, RD_LAT=1 -> p0_gnt in cycle 0, p0_rvalid high cycle 2 with p0_rdata=26'h1234567, p0_stall=0 in cycle 0.
- p0 and p1 both request reads every cycle from reset -> grants alternate p0,p1,p0,p1, each separated by RD_LAT+1 cycles, no cycle with both gnt high.
- p1 write 26'h3FFFFFF to 16'hFFFF then p1 read 16'hFFFF -> mem_we=1 on first grant, read back 26'h3FFFFFF, p0 rdata unchanged at 0.
- p0_lock=1 with p0 doing read then write to 16'h0010 while p1 requests continuously -> p0 granted twice in a row, p1 granted only after p0_lock drops; p0_stall=1 during p1 service.
- RD_LAT=3, p0 read issued, rst asserted in the second WAIT cycle -> no p0_rvalid ever, state IDLE, next p0 request granted the cycle after rst deasserts.
- Back-to-back p0 writes to 16'h0000..16'h0003 with p1 idle -> four consecutive grant cycles, mem_addr 0,1,2,3, zero stall cycles.
